pic_host_sequencer: RTL and testbench
=====================================

# pic_host_sequencer

Host-side (CPU-end) initiator for the 8259 PIC control logic: after a start request it programs the PIC through the ICW/OCW strobe interface. It then answers each INT with the two-pulse active-low INTA acknowledge sequence and captures the 8-bit vector. It issues a non-specific EOI via OCW2 when the CPU signals service completion, unless auto-EOI is programmed. It sits between the bench/CPU model and the PIC top level, driving the PIC's A0, datain, ICWs, OCWs and INTA inputs.

## Interface
- VECTOR_BASE, 5'b00100: vector base, sent as ICW2[7:3].
- MASK, 8'h00: initial interrupt mask, sent as OCW1.
- AEOI, 1'b0: auto-EOI select, sent as ICW4[1]; also suppresses the OCW2 EOI write.
- PULSE_CYCLES, 2: INTA low width in clocks (≥1).
- GAP_CYCLES, 1: INTA high time between the two pulses, in clocks (≥1).

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to run initialization; ignored unless in IDLE.
- eoi_req  in  1  CPU service done; sampled only in SERVICE.
- INT  in  1  PIC interrupt request, level.
- din  in  8  PIC data bus toward host (vector).
- dout  out  8  command byte to PIC datain.
- A0  out  1  PIC address line.
- ICWs  out  4  one-hot ICW strobe, bit n = ICWn.
- OCWs  out  4  one-hot OCW strobe, bit n = OCWn; bit 4 is always 0.
- INTA  out  1  active-low acknowledge.
- busy  out  1  high in every state except IDLE and READY.
- init_done  out  1  high from entry to READY until reset.
- vector  out  8  last captured vector.
- vector_valid  out  1  one-cycle pulse when vector updates.

## Operation
- Reset values: state IDLE, dout=0, A0=0, ICWs=0, OCWs=0, INTA=1, busy=0, init_done=0, vector=0, vector_valid=0, INT synchronizer=0.
- States: IDLE, WR_ICW1, WR_ICW2, WR_ICW4, WR_OCW1, READY, ACK1, GAP, ACK2, SERVICE, WR_EOI.
- Each WR_* state lasts 2 cycles:
  - Phase 0: the strobe bit is high, with dout and A0 valid.
  - Phase 1: the strobe returns to 0 while dout and A0 are held.
  - Phase 1 guarantees a strobe change for the PIC's level-sensitive capture.
- Command bytes:
  - ICW1 = 8'h13 (A0=0; IC4=1, SNGL=1), so ICW3 is never written.
  - ICW2 = {VECTOR_BASE,3'b000} (A0=1).
  - ICW4 = {6'b0,AEOI,1'b1} (A0=1).
  - OCW1 = MASK (A0=1).
  - OCW2 = 8'h20, non-specific EOI (A0=0).
- Transitions:
  - IDLE→WR_ICW1 on start.
  - WR_ICW1→WR_ICW2→WR_ICW4→WR_OCW1→READY.
  - READY→ACK1 when the synchronized INT is 1.
  - ACK1 (INTA=0, PULSE_CYCLES) → GAP (INTA=1, GAP_CYCLES) → ACK2 (INTA=0, PULSE_CYCLES).
  - ACK2 → SERVICE if AEOI=0, otherwise → READY.
  - SERVICE→WR_EOI on eoi_req; WR_EOI→READY.
- Vector capture: vector ← din on the last clock of ACK2; vector_valid pulses on the following cycle.
- A duration counter, sized for max(PULSE_CYCLES,GAP_CYCLES), reloads on every state entry.

## Timing
- start at cycle 0 → ICWs=4'b0001 at cycle 1; the four writes occupy cycles 1–8; READY and init_done=1 at cycle 9.
- INT passes through one register stage, then READY decodes it: INTA falls 2 cycles after INT rises.
- INTA low spans exactly PULSE_CYCLES clocks per pulse; the high gap spans exactly GAP_CYCLES clocks.
- With AEOI=1 the FSM re-enters READY the cycle after ACK2. If INT is still 1 there, a new ack starts immediately (level-sensitive).
- Boundary conditions:
  - INT during init, SERVICE or WR_EOI: ignored; it is evaluated only in READY.
  - INT dropping mid-ack: the sequence completes unchanged.
  - start outside IDLE: ignored; re-init requires rst.
  - eoi_req outside SERVICE: ignored, not queued.
  - rst in any state, including INTA low: all outputs take reset values on the next edge; INTA returns to 1.

## Test plan
- Init: rst then start → ICWs pulses 0001,0010,1000 with dout 13h, 20h (VECTOR_BASE=4), 03h/01h by AEOI; OCWs=0001 with dout=MASK; init_done high at cycle 9.
- Ack with AEOI=0, PULSE_CYCLES=2, GAP_CYCLES=1, din=8'h22 → INTA low 2 clocks, high 1, low 2; vector=22h with a one-cycle vector_valid; FSM stays in SERVICE.
- EOI: eoi_req in SERVICE → OCWs=0001_0 pattern 4'b0010 with dout=20h, A0=0 for 1 cycle; READY follows.
- AEOI=1: INT held high → back-to-back ack sequences, no OCW2 writes, vector_valid once per sequence.
- Ignored events: INT high during init, start in READY, eoi_req in READY → no state change; init completes normally.
- Reset mid-ACK1 → INTA=1 and all outputs at reset values on the next edge; a new start re-runs the full init.

Source files
------------

// File: rtl/pic_host_sequencer.sv
// pic_host_sequencer: CPU-side driver for the 8259 control logic.
// Programs ICW1/ICW2/ICW4/OCW1 after start, then answers each INT with a
// two-pulse INTA sequence, latches the vector and (unless auto-EOI) issues
// a non-specific EOI through OCW2 once the CPU reports service completion.
module pic_host_sequencer #(
    parameter logic [4:0] VECTOR_BASE  = 5'b00100,
    parameter logic [7:0] MASK         = 8'h00,
    parameter logic       AEOI         = 1'b0,
    parameter int         PULSE_CYCLES = 2,
    parameter int         GAP_CYCLES   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       eoi_req,
    input  logic       INT,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       A0,
    output logic [3:0] ICWs,
    output logic [3:0] OCWs,
    output logic       INTA,
    output logic       busy,
    output logic       init_done,
    output logic [7:0] vector,
    output logic       vector_valid
);

    // Counter must hold the longest dwell minus one; write states need 2 cycles.
    localparam int MAXC = (PULSE_CYCLES > GAP_CYCLES) ?
                          ((PULSE_CYCLES > 2) ? PULSE_CYCLES : 2) :
                          ((GAP_CYCLES > 2) ? GAP_CYCLES : 2);
    localparam int CW   = $clog2(MAXC);

    typedef enum logic [3:0] {
        IDLE, WR_ICW1, WR_ICW2, WR_ICW4, WR_OCW1, READY,
        ACK1, GAP, ACK2, SERVICE, WR_EOI
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          int_s;
    logic          phase0;
    logic          cnt_done;

    // Dwell length (minus one) loaded when a state is entered.
    function automatic logic [CW-1:0] reload(input state_t s);
        logic [CW-1:0] r;
        r = '0;
        case (s)
            WR_ICW1, WR_ICW2, WR_ICW4, WR_OCW1, WR_EOI: r = CW'(1);
            ACK1, ACK2: r = CW'(PULSE_CYCLES - 1);
            GAP:        r = CW'(GAP_CYCLES - 1);
            default:    r = '0;
        endcase
        return r;
    endfunction

    // Write states: strobe high while cnt is 1 (phase 0), low while 0 (phase 1).
    assign phase0   = (cnt != '0);
    assign cnt_done = (cnt == '0);

    // State register and dwell counter; counter reloads on every state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                cnt <= reload(state_nxt);
            else if (cnt != '0)
                cnt <= cnt - CW'(1);
        end
    end

    // Next-state decode; INT only matters in READY, eoi_req only in SERVICE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)    state_nxt = WR_ICW1;
            WR_ICW1: if (cnt_done) state_nxt = WR_ICW2;
            WR_ICW2: if (cnt_done) state_nxt = WR_ICW4;
            WR_ICW4: if (cnt_done) state_nxt = WR_OCW1;
            WR_OCW1: if (cnt_done) state_nxt = READY;
            READY:   if (int_s)    state_nxt = ACK1;
            ACK1:    if (cnt_done) state_nxt = GAP;
            GAP:     if (cnt_done) state_nxt = ACK2;
            ACK2:    if (cnt_done) state_nxt = AEOI ? READY : SERVICE;
            SERVICE: if (eoi_req)  state_nxt = WR_EOI;
            WR_EOI:  if (cnt_done) state_nxt = READY;
            default: state_nxt = IDLE;
        endcase
    end

    // Bus, strobe and status outputs decoded from the current state.
    always_comb begin
        dout      = 8'h00;
        A0        = 1'b0;
        ICWs      = 4'b0000;
        OCWs      = 4'b0000;
        INTA      = 1'b1;
        busy      = !(state == IDLE || state == READY);
        init_done = !(state == IDLE || state == WR_ICW1 || state == WR_ICW2 ||
                      state == WR_ICW4 || state == WR_OCW1);
        case (state)
            WR_ICW1: begin
                dout = 8'h13;
                ICWs = phase0 ? 4'b0001 : 4'b0000;
            end
            WR_ICW2: begin
                dout = {VECTOR_BASE, 3'b000};
                A0   = 1'b1;
                ICWs = phase0 ? 4'b0010 : 4'b0000;
            end
            WR_ICW4: begin
                dout = {6'b000000, AEOI, 1'b1};
                A0   = 1'b1;
                ICWs = phase0 ? 4'b1000 : 4'b0000;
            end
            WR_OCW1: begin
                dout = MASK;
                A0   = 1'b1;
                OCWs = phase0 ? 4'b0001 : 4'b0000;
            end
            WR_EOI: begin
                dout = 8'h20;
                OCWs = phase0 ? 4'b0010 : 4'b0000;
            end
            ACK1, ACK2: INTA = 1'b0;
            default: ;
        endcase
    end

    // INT synchronizer and vector latch on the final ACK2 clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            int_s        <= 1'b0;
            vector       <= 8'h00;
            vector_valid <= 1'b0;
        end else begin
            int_s        <= INT;
            vector_valid <= 1'b0;
            if (state == ACK2 && cnt_done) begin
                vector       <= din;
                vector_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pic_host_sequencer.sv
// tb_pic_host_sequencer: randomized bench for two sequencer builds
// (default AEOI=0 and an AEOI=1 build with wider pulses). Expected values
// come from the timing rules: write k occupies cycles 2k+1/2k+2 after start,
// INTA falls two cycles after INT, then P low / G high / P low.
module tb_pic_host_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, eoi_req, int_r;
    logic [7:0] din;

    logic [7:0] o_dout   [2];
    logic       o_a0     [2];
    logic [3:0] o_icws   [2];
    logic [3:0] o_ocws   [2];
    logic       o_inta   [2];
    logic       o_busy   [2];
    logic       o_idone  [2];
    logic [7:0] o_vec    [2];
    logic       o_vv     [2];

    int sel;
    int n_chk  = 0;
    int n_pass = 0;

    // model parameters of the DUT under check
    logic [4:0] m_vb;
    logic [7:0] m_mask;
    logic       m_aeoi;
    int         m_p, m_g;

    pic_host_sequencer #(.VECTOR_BASE(5'b00100), .MASK(8'h00), .AEOI(1'b0),
                         .PULSE_CYCLES(2), .GAP_CYCLES(1)) dut0 (
        .clk(clk), .rst(rst), .start(start), .eoi_req(eoi_req), .INT(int_r),
        .din(din), .dout(o_dout[0]), .A0(o_a0[0]), .ICWs(o_icws[0]),
        .OCWs(o_ocws[0]), .INTA(o_inta[0]), .busy(o_busy[0]),
        .init_done(o_idone[0]), .vector(o_vec[0]), .vector_valid(o_vv[0]));

    pic_host_sequencer #(.VECTOR_BASE(5'b10101), .MASK(8'h5A), .AEOI(1'b1),
                         .PULSE_CYCLES(3), .GAP_CYCLES(2)) dut1 (
        .clk(clk), .rst(rst), .start(start), .eoi_req(eoi_req), .INT(int_r),
        .din(din), .dout(o_dout[1]), .A0(o_a0[1]), .ICWs(o_icws[1]),
        .OCWs(o_ocws[1]), .INTA(o_inta[1]), .busy(o_busy[1]),
        .init_done(o_idone[1]), .vector(o_vec[1]), .vector_valid(o_vv[1]));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s (dut%0d): got %0h expected %0h", tag, sel, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_dout"},  32'(o_dout[sel]),  32'h00);
        chk({tag, "_a0"},    32'(o_a0[sel]),    32'h0);
        chk({tag, "_icws"},  32'(o_icws[sel]),  32'h0);
        chk({tag, "_ocws"},  32'(o_ocws[sel]),  32'h0);
        chk({tag, "_inta"},  32'(o_inta[sel]),  32'h1);
        chk({tag, "_busy"},  32'(o_busy[sel]),  32'h0);
        chk({tag, "_idone"}, 32'(o_idone[sel]), 32'h0);
        chk({tag, "_vec"},   32'(o_vec[sel]),   32'h00);
        chk({tag, "_vv"},    32'(o_vv[sel]),    32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; eoi_req = 1'b0; int_r = 1'b0; din = 8'h00;
        tick();
        tick();
        chk_reset("rst");
        rst = 1'b0;
        tick();
        chk_reset("idle_hold");
    endtask

    // start pulse, then four two-cycle writes; optional INT/start/eoi noise
    task automatic run_init(input bit noise);
        int         k;
        bit         ph0;
        logic [3:0] e_icw, e_ocw;
        logic [7:0] e_d;
        logic       e_a0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            k   = (cyc - 1) / 2;
            ph0 = ((cyc - 1) % 2) == 0;
            e_icw = 4'b0000;
            e_ocw = 4'b0000;
            case (k)
                0: begin e_d = 8'h13;             e_a0 = 1'b0; if (ph0) e_icw = 4'b0001; end
                1: begin e_d = {m_vb, 3'b000};    e_a0 = 1'b1; if (ph0) e_icw = 4'b0010; end
                2: begin e_d = {6'b0, m_aeoi, 1'b1}; e_a0 = 1'b1; if (ph0) e_icw = 4'b1000; end
                default: begin e_d = m_mask;      e_a0 = 1'b1; if (ph0) e_ocw = 4'b0001; end
            endcase
            chk("init_icws",  32'(o_icws[sel]),  32'(e_icw));
            chk("init_ocws",  32'(o_ocws[sel]),  32'(e_ocw));
            chk("init_dout",  32'(o_dout[sel]),  32'(e_d));
            chk("init_a0",    32'(o_a0[sel]),    32'(e_a0));
            chk("init_busy",  32'(o_busy[sel]),  32'h1);
            chk("init_idone", 32'(o_idone[sel]), 32'h0);
            chk("init_inta",  32'(o_inta[sel]),  32'h1);
            if (noise) begin
                int_r   = 1'($urandom_range(0, 1));
                start   = 1'($urandom_range(0, 1));
                eoi_req = 1'($urandom_range(0, 1));
            end
            if (cyc == 8) begin int_r = 1'b0; start = 1'b0; eoi_req = 1'b0; end
            tick();
        end
        chk("ready_idone", 32'(o_idone[sel]), 32'h1);
        chk("ready_busy",  32'(o_busy[sel]),  32'h0);
        chk("ready_icws",  32'(o_icws[sel]),  32'h0);
        chk("ready_ocws",  32'(o_ocws[sel]),  32'h0);
    endtask

    // start / eoi_req in READY must not move the FSM
    task automatic ready_ignored(input int n);
        for (int i = 0; i < n; i++) begin
            start   = 1'($urandom_range(0, 1));
            eoi_req = 1'($urandom_range(0, 1));
            tick();
            chk("ign_busy",  32'(o_busy[sel]),  32'h0);
            chk("ign_idone", 32'(o_idone[sel]), 32'h1);
            chk("ign_icws",  32'(o_icws[sel]),  32'h0);
            chk("ign_ocws",  32'(o_ocws[sel]),  32'h0);
            chk("ign_inta",  32'(o_inta[sel]),  32'h1);
        end
        start   = 1'b0;
        eoi_req = 1'b0;
    endtask

    // raise INT in READY; one cycle later INTA has not fallen yet
    task automatic ack_begin();
        int_r = 1'b1;
        chk("pre_inta", 32'(o_inta[sel]), 32'h1);
        tick();
        chk("lat_inta", 32'(o_inta[sel]), 32'h1);
        chk("lat_busy", 32'(o_busy[sel]), 32'h0);
    endtask

    // precondition: DUT in READY with INT already synchronized high
    task automatic ack_seq(input logic [7:0] vec, input bit drop);
        int len;
        len = 2 * m_p + m_g;
        for (int i = 0; i < len; i++) begin
            tick();
            chk("ack_inta", 32'(o_inta[sel]), (i < m_p || i >= m_p + m_g) ? 32'h0 : 32'h1);
            chk("ack_busy", 32'(o_busy[sel]), 32'h1);
            chk("ack_vv",   32'(o_vv[sel]),   32'h0);
            chk("ack_ocws", 32'(o_ocws[sel]), 32'h0);
            if (drop && i == m_p) int_r = 1'b0;
            eoi_req = 1'($urandom_range(0, 1));
            din     = (i == len - 1) ? vec : ~vec;
        end
        tick();
        eoi_req = 1'b0;
        din     = ~vec;
        chk("cap_vec",  32'(o_vec[sel]),  32'(vec));
        chk("cap_vv",   32'(o_vv[sel]),   32'h1);
        chk("cap_inta", 32'(o_inta[sel]), 32'h1);
        chk("cap_busy", 32'(o_busy[sel]), m_aeoi ? 32'h0 : 32'h1);
    endtask

    // SERVICE dwell with INT noise, then eoi_req -> OCW2 write -> READY
    task automatic eoi_service();
        int w;
        w = $urandom_range(0, 3);
        for (int i = 0; i < w; i++) begin
            int_r   = 1'($urandom_range(0, 1));
            eoi_req = 1'b0;
            tick();
            chk("svc_busy", 32'(o_busy[sel]), 32'h1);
            chk("svc_inta", 32'(o_inta[sel]), 32'h1);
            chk("svc_ocws", 32'(o_ocws[sel]), 32'h0);
            chk("svc_vv",   32'(o_vv[sel]),   32'h0);
        end
        int_r   = 1'b0;
        eoi_req = 1'b1;
        tick();
        eoi_req = 1'b0;
        chk("eoi0_ocws", 32'(o_ocws[sel]), 32'h2);
        chk("eoi0_dout", 32'(o_dout[sel]), 32'h20);
        chk("eoi0_a0",   32'(o_a0[sel]),   32'h0);
        chk("eoi0_icws", 32'(o_icws[sel]), 32'h0);
        chk("eoi0_busy", 32'(o_busy[sel]), 32'h1);
        tick();
        chk("eoi1_ocws", 32'(o_ocws[sel]), 32'h0);
        chk("eoi1_dout", 32'(o_dout[sel]), 32'h20);
        chk("eoi1_a0",   32'(o_a0[sel]),   32'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("post_busy",  32'(o_busy[sel]),  32'h0);
            chk("post_idone", 32'(o_idone[sel]), 32'h1);
            chk("post_inta",  32'(o_inta[sel]),  32'h1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int n;
        // ---- build 0: AEOI=0, P=2, G=1 ----
        sel = 0; m_vb = 5'b00100; m_mask = 8'h00; m_aeoi = 1'b0; m_p = 2; m_g = 1;
        do_reset();
        run_init(1'b1);
        ready_ignored(3);
        ack_begin();
        ack_seq(8'h22, 1'b0);
        eoi_service();
        for (int j = 0; j < 4; j++) begin
            ack_begin();
            ack_seq(8'($urandom), 1'($urandom_range(0, 1)));
            eoi_service();
        end
        // reset while INTA is low, then full re-init
        ack_begin();
        tick();
        chk("ack1_inta", 32'(o_inta[sel]), 32'h0);
        rst = 1'b1;
        int_r = 1'b0;
        tick();
        chk_reset("midrst");
        rst = 1'b0;
        run_init(1'b0);
        ack_begin();
        ack_seq(8'($urandom), 1'b1);
        eoi_service();

        // ---- build 1: AEOI=1, P=3, G=2 ----
        sel = 1; m_vb = 5'b10101; m_mask = 8'h5A; m_aeoi = 1'b1; m_p = 3; m_g = 2;
        do_reset();
        run_init(1'b1);
        ready_ignored(3);
        ack_begin();
        n = 3 + $urandom_range(0, 1);
        for (int j = 0; j < n; j++)
            ack_seq(8'($urandom), j == n - 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("aeoi_idle_inta", 32'(o_inta[sel]), 32'h1);
            chk("aeoi_idle_busy", 32'(o_busy[sel]), 32'h0);
            chk("aeoi_idle_ocws", 32'(o_ocws[sel]), 32'h0);
            chk("aeoi_idle_vv",   32'(o_vv[sel]),   32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
